// File: rtl/pixel_scan_sequencer.sv
// pixel_scan_sequencer: walks pixel coordinates in raster order, issues them to the compute
// engine under a bounded in-flight credit, and emits the in-order results as an AXI4-Stream
// video frame (tuser = start of frame, tlast = end of line).
// Build option SEQ_OUT_REG_EN: register the output stream through a 2-entry skid buffer.
// Without it, results pass combinationally from the engine to the stream.
module pixel_scan_sequencer #(
  parameter int unsigned X_SIZE       = 640,
  parameter int unsigned Y_SIZE       = 480,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                frame_done,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [15:0]         req_x,
  output logic [15:0]         req_y,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [DATA_W-1:0]   res_data,
  output logic [DATA_W-1:0]   out_stream_tdata,
  output logic [DATA_W/8-1:0] out_stream_tkeep,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready,
  output logic                out_stream_tuser,
  output logic                out_stream_tlast
);

  localparam logic [15:0] XLast       = 16'(X_SIZE - 1);
  localparam logic [15:0] YLast       = 16'(Y_SIZE - 1);
  localparam logic [3:0]  MaxInflight = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e      state_q;
  logic        busy_q;
  logic        frame_done_q;
  logic [15:0] ix_q, iy_q;
  logic [15:0] ox_q, oy_q;
  logic [3:0]  inflight_q;
  logic        first_q;
  logic        last_q;

  logic accepting;
  logic req_hs;
  logic res_hs;
  logic out_hs;
  logic out_final;

  // Results are taken only while a frame is live; the frame_done cycle already belongs to
  // the next frame boundary, so nothing is accepted then.
  assign accepting = (state_q == StRun) || ((state_q == StDrain) && !frame_done_q);

  assign req_valid = (state_q == StRun) && (inflight_q < MaxInflight);
  assign req_x     = ix_q;
  assign req_y     = iy_q;
  assign busy      = busy_q;
  assign frame_done = frame_done_q;

  assign req_hs    = req_valid && req_ready;
  assign res_hs    = res_valid && res_ready;
  assign out_hs    = out_stream_tvalid && out_stream_tready;
  assign out_final = out_hs && (ox_q == XLast) && (oy_q == YLast);

  assign out_stream_tkeep = '1;
  assign out_stream_tuser = first_q;
  assign out_stream_tlast = last_q;

  // Frame FSM together with issue, output-position and credit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ix_q         <= '0;
      iy_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      inflight_q   <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      frame_done_q <= out_final;

      if (req_hs && !res_hs) begin
        inflight_q <= inflight_q + 4'd1;
      end else if (res_hs && !req_hs) begin
        inflight_q <= inflight_q - 4'd1;
      end

      // first_q/last_q track the position of the word currently on the stream, so they
      // are ready as flops before the word is presented.
      if (out_hs) begin
        first_q <= 1'b0;
        if (ox_q == XLast) begin
          ox_q   <= '0;
          last_q <= 1'b0;
          oy_q   <= (oy_q == YLast) ? '0 : oy_q + 16'd1;
        end else begin
          ox_q   <= ox_q + 16'd1;
          last_q <= (ox_q == XLast - 16'd1);
        end
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            ix_q       <= '0;
            iy_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            inflight_q <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
          end
        end
        StRun: begin
          if (req_hs) begin
            if (ix_q == XLast) begin
              ix_q <= '0;
              if (iy_q == YLast) begin
                iy_q    <= '0;
                state_q <= StDrain;
              end else begin
                iy_q <= iy_q + 16'd1;
              end
            end else begin
              ix_q <= ix_q + 16'd1;
            end
          end
        end
        StDrain: begin
          if (frame_done_q) begin
            if (continuous) begin
              state_q    <= StRun;
              ix_q       <= '0;
              iy_q       <= '0;
              ox_q       <= '0;
              oy_q       <= '0;
              inflight_q <= '0;
              first_q    <= 1'b1;
              last_q     <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_OUT_REG_EN
  logic              out_valid_q;
  logic              skid_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] skid_data_q;

  // Full means the second entry is occupied; it is only used while the head is stalled.
  assign res_ready         = accepting && !skid_valid_q;
  assign out_stream_tvalid = out_valid_q;
  assign out_stream_tdata  = out_data_q;

  // Two-entry skid buffer: head drives the stream, second entry absorbs one stalled result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      if (!out_valid_q || out_stream_tready) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          skid_valid_q <= res_hs;
          if (res_hs) begin
            skid_data_q <= res_data;
          end
        end else begin
          out_valid_q <= res_hs;
          if (res_hs) begin
            out_data_q <= res_data;
          end
        end
      end else if (res_hs) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= res_data;
      end
    end
  end
`else
  assign out_stream_tvalid = accepting && res_valid;
  assign res_ready         = accepting && out_stream_tready;
  assign out_stream_tdata  = accepting ? res_data : '0;
`endif

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Bench for pixel_scan_sequencer: a 3-cycle in-order engine model plus a raster-order
// scoreboard of expected coordinates and stream words, with randomized backpressure.
module tb_pixel_scan_sequencer;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int MI = 2;
  localparam int DW = 32;
  localparam int FRAME = XS * YS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          busy;
  logic          frame_done;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_x;
  logic [15:0]   req_y;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [DW-1:0] out_stream_tdata;
  logic [DW/8-1:0] out_stream_tkeep;
  logic          out_stream_tvalid;
  logic          out_stream_tready;
  logic          out_stream_tuser;
  logic          out_stream_tlast;

  always #5 clk = ~clk;

  pixel_scan_sequencer #(
    .X_SIZE      (XS),
    .Y_SIZE      (YS),
    .MAX_INFLIGHT(MI),
    .DATA_W      (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .continuous       (continuous),
    .busy             (busy),
    .frame_done       (frame_done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_x            (req_x),
    .req_y            (req_y),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .out_stream_tdata (out_stream_tdata),
    .out_stream_tkeep (out_stream_tkeep),
    .out_stream_tvalid(out_stream_tvalid),
    .out_stream_tready(out_stream_tready),
    .out_stream_tuser (out_stream_tuser),
    .out_stream_tlast (out_stream_tlast)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } eng_t;

  eng_t eng_q[$];
  int   cycle = 0;
  bit   stall = 0;
  bit   stray = 0;
  bit   rand_out = 0;
  bit   rand_req = 0;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int word_cnt = 0;
  int tb_inflight = 0;
  int done_cnt = 0;
  int tuser_cnt = 0;
  int tlast_cnt = 0;
  bit done_due = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_req_valid", 32'(req_valid), 32'd0);
    check_eq("rst_req_x", 32'(req_x), 32'd0);
    check_eq("rst_req_y", 32'(req_y), 32'd0);
    check_eq("rst_res_ready", 32'(res_ready), 32'd0);
    check_eq("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    check_eq("rst_tuser", 32'(out_stream_tuser), 32'd0);
    check_eq("rst_tlast", 32'(out_stream_tlast), 32'd0);
    check_eq("rst_tdata", out_stream_tdata, 32'd0);
    check_eq("rst_tkeep", 32'(out_stream_tkeep), 32'hf);
  endtask

  // One clock: score handshakes at the falling edge, then update the engine and drive inputs.
  task automatic step();
    bit          s_req, s_res, s_out, s_final;
    int          k;
    logic [31:0] req_word;
    eng_t        e;
    @(negedge clk);
    s_req   = req_valid && req_ready;
    s_res   = res_valid && res_ready;
    s_out   = out_stream_tvalid && out_stream_tready;
    s_final = 1'b0;
    req_word = 32'(req_x) + 32'd16 * 32'(req_y);
    check_eq("frame_done", 32'(frame_done), 32'(done_due));
    if (frame_done) done_cnt++;
    if (s_req) begin
      check_eq("req_x", 32'(req_x), 32'(req_cnt % XS));
      check_eq("req_y", 32'(req_y), 32'((req_cnt / XS) % YS));
      req_cnt++;
    end
    if (s_req && !s_res) tb_inflight++;
    else if (s_res && !s_req) tb_inflight--;
    if (s_req) check_eq("inflight_bound", 32'(tb_inflight <= MI), 32'd1);
    if (s_out) begin
      k = word_cnt % FRAME;
      check_eq("tdata", out_stream_tdata, 32'((k % XS) + 16 * (k / XS)));
      check_eq("tuser", 32'(out_stream_tuser), 32'(k == 0));
      check_eq("tlast", 32'(out_stream_tlast), 32'((k % XS) == XS - 1));
      if (out_stream_tuser) tuser_cnt++;
      if (out_stream_tlast) tlast_cnt++;
      s_final = (k == FRAME - 1);
      word_cnt++;
    end
    done_due = s_final;
    @(posedge clk);
    #1;
    if (s_req) begin
      e.due  = cycle + 3;
      e.data = req_word;
      eng_q.push_back(e);
    end
    if (s_res && !stray && eng_q.size() > 0) void'(eng_q.pop_front());
    cycle++;
    if (stray) begin
      res_valid = 1'b1;
      res_data  = 32'hdead_beef;
    end else if (eng_q.size() > 0 && eng_q[0].due <= cycle && !stall) begin
      res_valid = 1'b1;
      res_data  = eng_q[0].data;
    end else begin
      res_valid = 1'b0;
      res_data  = '0;
    end
    out_stream_tready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
    req_ready         = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
  endtask

  task automatic run_until_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check_eq("done_count", 32'(done_cnt), 32'(target));
  endtask

  int base_req, base_word, base_user, base_last, n;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    req_ready = 1'b1;
    res_valid = 1'b0;
    res_data = '0;
    out_stream_tready = 1'b1;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, everything ready
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t1_busy_after_start", 32'(busy), 32'd1);
    check_eq("t1_req_valid_after_start", 32'(req_valid), 32'd1);
    run_until_done(1, 200);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_words", 32'(word_cnt), 32'd8);
    check_eq("t1_tuser", 32'(tuser_cnt), 32'd1);
    check_eq("t1_tlast", 32'(tlast_cnt), 32'd2);

    // Engine withholds results: credit must cap requests at MI
    base_req = req_cnt;
    base_word = word_cnt;
    stall = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check_eq("t2_reqs_stalled", 32'(req_cnt - base_req), 32'(MI));
    check_eq("t2_req_valid_low", 32'(req_valid), 32'd0);
    stall = 1'b0;
    run_until_done(2, 300);
    check_eq("t2_words", 32'(word_cnt - base_word), 32'(FRAME));

    // Three continuous frames under random backpressure on both sides
    base_req = req_cnt;
    base_word = word_cnt;
    base_user = tuser_cnt;
    base_last = tlast_cnt;
    rand_out = 1'b1;
    rand_req = 1'b1;
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(4, 2000);
    continuous = 1'b0;
    run_until_done(5, 2000);
    rand_out = 1'b0;
    rand_req = 1'b0;
    check_eq("t3_words", 32'(word_cnt - base_word), 32'(3 * FRAME));
    check_eq("t3_reqs", 32'(req_cnt - base_req), 32'(3 * FRAME));
    check_eq("t3_tuser", 32'(tuser_cnt - base_user), 32'd3);
    check_eq("t3_tlast", 32'(tlast_cnt - base_last), 32'(3 * YS));
    check_eq("t3_busy_end", 32'(busy), 32'd0);

    // Reset mid-frame after 5 stream words
    base_word = word_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (word_cnt < base_word + 5 && n < 200) begin
      step();
      n++;
    end
    check_eq("t4_words_before_rst", 32'(word_cnt - base_word), 32'd5);
    rst = 1'b1;
    stray = 1'b1;
    #1;
    check_reset_outputs();
    eng_q.delete();
    tb_inflight = 0;
    req_cnt = 0;
    word_cnt = 0;
    done_due = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check_eq("t4_res_ready_idle", 32'(res_ready), 32'd0);
      check_eq("t4_tvalid_idle", 32'(out_stream_tvalid), 32'd0);
    end
    stray = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(6, 300);
    check_eq("t4_words_after_rst", 32'(word_cnt), 32'(FRAME));
    check_eq("t4_busy_end", 32'(busy), 32'd0);

    // Stray results in IDLE are held off; start while busy is ignored
    stray = 1'b1;
    repeat (5) begin
      step();
      check_eq("t5_res_ready_idle", 32'(res_ready), 32'd0);
      check_eq("t5_tvalid_idle", 32'(out_stream_tvalid), 32'd0);
      check_eq("t5_busy_idle", 32'(busy), 32'd0);
    end
    stray = 1'b0;
    step();
    base_req = req_cnt;
    base_word = word_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(7, 300);
    check_eq("t5_busy_end", 32'(busy), 32'd0);
    repeat (10) step();
    check_eq("t5_busy_after", 32'(busy), 32'd0);
    check_eq("t5_words", 32'(word_cnt - base_word), 32'(FRAME));
    check_eq("t5_reqs", 32'(req_cnt - base_req), 32'(FRAME));
    check_eq("t5_done_total", 32'(done_cnt), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
